// File: rtl/jfif_pkt_sched_if.sv
// JFIF scheduler bus: FIFO read side, transmitter side and frame status.
// master = scheduler, slave = FIFO/transmitter environment.
interface jfif_pkt_sched_if;
    logic [7:0] fifo_rd_data;
    logic       fifo_empty;
    logic       fifo_rd_req;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       frame_done;
    logic [7:0] frame_id;

    modport master (
        input  fifo_rd_data, fifo_empty, tx_ready,
        output fifo_rd_req, tx_data, tx_valid, tx_last, frame_done, frame_id
    );

    modport slave (
        output fifo_rd_data, fifo_empty, tx_ready,
        input  fifo_rd_req, tx_data, tx_valid, tx_last, frame_done, frame_id
    );
endinterface

// File: rtl/jfif_pkt_sched.sv
// Cuts the JFIF byte stream into packets (4-byte header, <=PKT_LEN payload, EOI closes early); JFIF_PKT_CSUM_EN appends an XOR checksum byte.
// Latency: one registered output stage; header follows IDLE by one cycle, payload byte leaves the cycle after its pop.
// Backpressure: output register only loads when empty or accepted, so FIFO pops stall with tx_ready; empty FIFO inserts bubbles.
module jfif_pkt_sched #(
    parameter int         PKT_LEN = 256,
    parameter logic [7:0] SYNC0   = 8'h55,
    parameter logic [7:0] SYNC1   = 8'hAA
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    jfif_pkt_sched_if.master   bus
);

`ifdef JFIF_PKT_CSUM_EN
    typedef enum logic [7:0] {
        IDLE  = 8'b0000_0001,
        HDR0  = 8'b0000_0010,
        HDR1  = 8'b0000_0100,
        HDR2  = 8'b0000_1000,
        HDR3  = 8'b0001_0000,
        PAY   = 8'b0010_0000,
        DRAIN = 8'b0100_0000,
        CSUM  = 8'b1000_0000
    } state_t;
`else
    typedef enum logic [6:0] {
        IDLE  = 7'b000_0001,
        HDR0  = 7'b000_0010,
        HDR1  = 7'b000_0100,
        HDR2  = 7'b000_1000,
        HDR3  = 7'b001_0000,
        PAY   = 7'b010_0000,
        DRAIN = 7'b100_0000
    } state_t;
`endif

    state_t     state, state_nxt;
    logic [7:0] tx_data_q;
    logic       tx_valid_q;
    logic       tx_last_q;
    logic       frame_done_q;
    logic [7:0] frame_id_q;
    logic [7:0] pkt_idx;
    logic [8:0] pay_cnt;
    logic       prev_ff;
    logic       eoi_q;
`ifdef JFIF_PKT_CSUM_EN
    logic [7:0] csum;
`endif

    logic       ld;
    logic       xfer;
    logic       pay_take;
    logic       byte_eoi;
    logic       byte_len;
    logic       pkt_end;
    logic       out_ld;
    logic [7:0] out_dat;
    logic       out_vld;
    logic       out_last;

    assign ld       = !tx_valid_q || bus.tx_ready;
    assign xfer     = tx_valid_q && bus.tx_ready;
    assign pay_take = (state == PAY) && ld && !bus.fifo_empty;
    assign byte_eoi = prev_ff && (bus.fifo_rd_data == 8'hD9);
    assign byte_len = (pay_cnt + 9'd1) == 9'(PKT_LEN);
    assign pkt_end  = byte_eoi || byte_len;

    assign bus.fifo_rd_req = pay_take;
    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.tx_last     = tx_last_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.frame_id    = frame_id_q;

    always_comb begin
        state_nxt = state;
        out_ld    = 1'b0;
        out_dat   = tx_data_q;
        out_vld   = tx_valid_q;
        out_last  = tx_last_q;
        case (state)
            IDLE: if (!bus.fifo_empty) state_nxt = HDR0;
            HDR0, HDR1, HDR2, HDR3: begin
                if (ld) begin
                    out_ld   = 1'b1;
                    out_vld  = 1'b1;
                    out_last = 1'b0;
                    case (state)
                        HDR0:    begin out_dat = SYNC0;      state_nxt = HDR1; end
                        HDR1:    begin out_dat = SYNC1;      state_nxt = HDR2; end
                        HDR2:    begin out_dat = frame_id_q; state_nxt = HDR3; end
                        default: begin out_dat = pkt_idx;    state_nxt = PAY;  end
                    endcase
                end
            end
            PAY: begin
                if (ld) begin
                    out_ld   = 1'b1;
                    out_last = 1'b0;
                    if (bus.fifo_empty) begin
                        out_vld = 1'b0;
                    end else begin
                        out_dat = bus.fifo_rd_data;
                        out_vld = 1'b1;
                        if (pkt_end) begin
`ifdef JFIF_PKT_CSUM_EN
                            state_nxt = CSUM;
`else
                            out_last  = 1'b1;
                            state_nxt = DRAIN;
`endif
                        end
                    end
                end
            end
`ifdef JFIF_PKT_CSUM_EN
            CSUM: begin
                if (ld) begin
                    out_ld    = 1'b1;
                    out_dat   = csum;
                    out_vld   = 1'b1;
                    out_last  = 1'b1;
                    state_nxt = DRAIN;
                end
            end
`endif
            DRAIN: begin
                if (xfer) begin
                    out_ld    = 1'b1;
                    out_vld   = 1'b0;
                    out_last  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            tx_last_q    <= 1'b0;
            frame_done_q <= 1'b0;
            frame_id_q   <= 8'h00;
            pkt_idx      <= 8'h00;
            pay_cnt      <= 9'd0;
            prev_ff      <= 1'b0;
            eoi_q        <= 1'b0;
        end else begin
            state        <= state_nxt;
            frame_done_q <= 1'b0;
            if (out_ld) begin
                tx_data_q  <= out_dat;
                tx_valid_q <= out_vld;
                tx_last_q  <= out_last;
            end
            if (pay_take) begin
                pay_cnt <= pay_cnt + 9'd1;
                prev_ff <= (bus.fifo_rd_data == 8'hFF);
                if (pkt_end) eoi_q <= byte_eoi;
            end
            // EOI wins over length end: frame advances and the FF history is dropped.
            if ((state == DRAIN) && xfer) begin
                pay_cnt <= 9'd0;
                if (eoi_q) begin
                    frame_id_q   <= frame_id_q + 8'd1;
                    pkt_idx      <= 8'h00;
                    frame_done_q <= 1'b1;
                    prev_ff      <= 1'b0;
                end else begin
                    pkt_idx <= pkt_idx + 8'd1;
                end
            end
        end
    end

`ifdef JFIF_PKT_CSUM_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            csum <= 8'h00;
        end else if (state == IDLE) begin
            csum <= 8'h00;
        end else if ((state == HDR2) && ld) begin
            csum <= csum ^ frame_id_q;
        end else if ((state == HDR3) && ld) begin
            csum <= csum ^ pkt_idx;
        end else if (pay_take) begin
            csum <= csum ^ bus.fifo_rd_data;
        end
    end
`endif

endmodule

// File: tb/tb_jfif_pkt_sched.sv
// Randomized scoreboard bench for jfif_pkt_sched (PKT_LEN=4); checksum expectations follow JFIF_PKT_CSUM_EN.
module tb_jfif_pkt_sched;
    localparam int PKT_LEN = 4;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    jfif_pkt_sched_if bus();

    jfif_pkt_sched #(.PKT_LEN(PKT_LEN), .SYNC0(8'h55), .SYNC1(8'hAA)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo_q[$];
    logic [8:0] exp_q[$];     // {last, data}
    logic [7:0] exp_fid_q[$]; // frame_id expected at each frame_done
    logic       pop_pend = 1'b0;
    logic       popped = 1'b0;
    logic       mon_en = 1'b0;
    int         rdy_pct = 100;
    int         emp_pct = 0;

    // Packetizer reference model, byte by byte
    logic [7:0] m_frame = 8'h00;
    logic [7:0] m_idx = 8'h00;
    int         m_cnt = 0;
    logic       m_prev_ff = 1'b0;
    logic       m_in_pkt = 1'b0;
    logic [7:0] m_csum = 8'h00;

    task automatic model_byte(input logic [7:0] b);
        logic eoi, fin;
        if (!m_in_pkt) begin
            exp_q.push_back({1'b0, 8'h55});
            exp_q.push_back({1'b0, 8'hAA});
            exp_q.push_back({1'b0, m_frame});
            exp_q.push_back({1'b0, m_idx});
            m_in_pkt = 1'b1;
            m_cnt = 0;
            m_csum = m_frame ^ m_idx;
        end
        eoi = m_prev_ff && (b == 8'hD9);
        m_cnt++;
        fin = eoi || (m_cnt == PKT_LEN);
        m_csum ^= b;
        m_prev_ff = (b == 8'hFF);
`ifdef JFIF_PKT_CSUM_EN
        exp_q.push_back({1'b0, b});
        if (fin) exp_q.push_back({1'b1, m_csum});
`else
        exp_q.push_back({fin, b});
`endif
        if (fin) begin
            m_in_pkt = 1'b0;
            if (eoi) begin
                m_frame = m_frame + 8'd1;
                m_idx = 8'h00;
                m_prev_ff = 1'b0;
                exp_fid_q.push_back(m_frame);
            end else begin
                m_idx = m_idx + 8'd1;
            end
        end
    endtask

    task automatic upd_fifo(input logic mask);
        bus.fifo_empty   = (fifo_q.size() == 0) || mask;
        bus.fifo_rd_data = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic push_byte(input logic [7:0] b);
        fifo_q.push_back(b);
        model_byte(b);
        upd_fifo(bus.fifo_empty && (fifo_q.size() > 1));
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
        if (pop_pend) void'(fifo_q.pop_front());
        pop_pend = 1'b0;
        bus.tx_ready = ($urandom_range(99) < rdy_pct);
        upd_fifo($urandom_range(99) < emp_pct);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: everything sampled on the falling edge
    logic       stall_prev = 1'b0;
    logic [8:0] stall_val = 9'd0;
    always @(negedge sys_clk) begin
        if (mon_en) begin
            if (stall_prev) begin
                checks++;
                if (!(bus.tx_valid && {bus.tx_last, bus.tx_data} == stall_val)) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b %0h, expected v=1 %0h",
                             bus.tx_valid, {bus.tx_last, bus.tx_data}, stall_val);
                end
            end
            if (bus.fifo_rd_req) begin
                checks++;
                if (bus.fifo_empty) begin
                    errors++;
                    $display("FAIL rd_req_empty: got rd_req=1 with empty=1, expected no pop");
                end
                pop_pend = 1'b1;
                popped = 1'b1;
            end
            if (bus.tx_valid && bus.tx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_unexpected: got %0h, expected nothing", {bus.tx_last, bus.tx_data});
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    if ({bus.tx_last, bus.tx_data} !== e) begin
                        errors++;
                        $display("FAIL tx_byte: got last=%0b data=%0h, expected last=%0b data=%0h",
                                 bus.tx_last, bus.tx_data, e[8], e[7:0]);
                    end
                end
            end
            if (bus.frame_done) begin
                checks++;
                if (exp_fid_q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_done_unexpected: got pulse at frame_id=%0h, expected none", bus.frame_id);
                end else begin
                    logic [7:0] f;
                    f = exp_fid_q.pop_front();
                    if (bus.frame_id !== f) begin
                        errors++;
                        $display("FAIL frame_id: got %0h, expected %0h", bus.frame_id, f);
                    end
                end
            end
            stall_prev = bus.tx_valid && !bus.tx_ready;
            stall_val  = {bus.tx_last, bus.tx_data};
        end
    end

    initial begin
        logic [7:0] short_frame [5];
        int n;
        short_frame = '{8'hFF, 8'hD8, 8'h01, 8'hFF, 8'hD9};
        bus.tx_ready = 1'b1;
        bus.fifo_empty = 1'b1;
        bus.fifo_rd_data = 8'h00;
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_tx_last", 32'(bus.tx_last), 32'd0);
        check("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check("rst_frame_done", 32'(bus.frame_done), 32'd0);
        check("rst_frame_id", 32'(bus.frame_id), 32'd0);
        check("rst_rd_req", 32'(bus.fifo_rd_req), 32'd0);
        mon_en = 1'b1;
        step();

        // Short frame at full rate
        for (int i = 0; i < 5; i++) push_byte(short_frame[i]);
        repeat (40) step();

        // Non-FF frame with a true underrun after two bytes, ending FF | D9 across a boundary
        for (int i = 0; i < 2; i++) push_byte(8'h10 + 8'(i));
        repeat (8) step();
        for (int i = 2; i < 10; i++) push_byte(8'h10 + 8'(i));
        push_byte(8'h33);
        push_byte(8'hFF);
        push_byte(8'hD9);
        repeat (60) step();

        // Random frames under random backpressure and underruns
        rdy_pct = 50;
        emp_pct = 30;
        for (int f = 0; f < 40; f++) begin
            n = $urandom_range(10);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(3))
                    0: push_byte(8'hFF);
                    1: push_byte(8'(8'h20 + $urandom_range(15)));
                    default: push_byte(8'($urandom_range(255)));
                endcase
            end
            push_byte(8'hFF);
            push_byte(8'hD9);
            repeat ($urandom_range(20)) step();
        end

        rdy_pct = 100;
        emp_pct = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            step();
            n++;
        end
        repeat (5) step();
        check("drain_exp_left", 32'(exp_q.size()), 32'd0);
        check("drain_fid_left", 32'(exp_fid_q.size()), 32'd0);
        check("fifo_left", 32'(fifo_q.size()), 32'd0);

        // Asynchronous reset in the middle of a payload
        popped = 1'b0;
        push_byte(8'h12);
        push_byte(8'h34);
        push_byte(8'h56);
        n = 0;
        while (!popped && n < 50) begin
            step();
            n++;
        end
        check("mid_payload_reached", 32'(popped), 32'd1);
        mon_en = 1'b0;
        sys_rst_n = 1'b0;
        #1;
        check("arst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("arst_tx_last", 32'(bus.tx_last), 32'd0);
        check("arst_tx_data", 32'(bus.tx_data), 32'd0);
        check("arst_frame_done", 32'(bus.frame_done), 32'd0);
        check("arst_frame_id", 32'(bus.frame_id), 32'd0);
        check("arst_rd_req", 32'(bus.fifo_rd_req), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
